// File: rtl/coin_collector.sv
// Coin pickup tracker: overlap detection, saturating score and tile write-back handshake.
// Optional respawn of collected coins is compiled in with `define COIN_COLLECTOR_RESPAWN_EN.
module coin_collector #(
   parameter int NUM_COINS       = 4,
   parameter int BLOCK_WIDTH     = 40,
   parameter int CHARACTER_WIDTH = 42,
   parameter int SCORE_WIDTH     = 10,
   parameter int COIN_VALUE      = 1,
   parameter int SKY             = 1,
   parameter int TKN             = 4,
   parameter int RESPAWN_CYCLES  = 1000
) (
   input  logic                        vga_clock,
   input  logic                        reset,
   input  logic signed [31:0]          mario_x,
   input  logic signed [31:0]          mario_y,
   input  logic [NUM_COINS*4-1:0]      coin_row,
   input  logic [NUM_COINS*5-1:0]      coin_col,
   input  logic [NUM_COINS-1:0]        coin_en,
   output logic                        tile_req,
   output logic [3:0]                  tile_row,
   output logic [4:0]                  tile_col,
   output logic [7:0]                  tile_data,
   input  logic                        tile_ack,
   output logic [NUM_COINS-1:0]        collected,
   output logic [SCORE_WIDTH-1:0]      score,
   output logic                        coin_event,
   output logic                        all_collected
);

   localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
   localparam int SUM_W = SCORE_WIDTH + 32;
   localparam logic [SUM_W-1:0] SCORE_MAX = {{32{1'b0}}, {SCORE_WIDTH{1'b1}}};

   if (NUM_COINS < 1 || NUM_COINS > 16) begin : g_bad_num_coins
      $error("coin_collector: NUM_COINS must be 1..16");
   end
   if (SKY < 0 || SKY > 255 || TKN < 0 || TKN > 255 || RESPAWN_CYCLES < 0) begin : g_bad_codes
      $error("coin_collector: tile codes must fit 8 bits, RESPAWN_CYCLES >= 0");
   end

   typedef enum logic {IDLE, REQ} wb_state_t;

   wb_state_t            state;
   logic [NUM_COINS-1:0] overlap;
   logic [NUM_COINS-1:0] hit;
   logic [NUM_COINS-1:0] clr_pend;
   logic [3:0]           row_of [NUM_COINS];
   logic [4:0]           col_of [NUM_COINS];
   logic [IDX_W-1:0]     cur_idx;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_valid;
   int unsigned          hit_cnt;
   logic [SUM_W-1:0]     score_sum;

`ifdef COIN_COLLECTOR_RESPAWN_EN
   localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES + 1) : 1;
   logic [NUM_COINS-1:0] rst_pend;
   logic [CNT_W-1:0]     respawn_cnt [NUM_COINS];
   logic                 req_restore;
   logic                 pick_restore;
`endif

   // Half-open interval test: strict compares make edge-touching tiles miss.
   for (genvar i = 0; i < NUM_COINS; i++) begin : g_coin
      logic signed [31:0] tile_x;
      logic signed [31:0] tile_y;
      assign row_of[i]  = coin_row[i*4 +: 4];
      assign col_of[i]  = coin_col[i*5 +: 5];
      assign tile_x     = $signed({27'd0, col_of[i]}) * BLOCK_WIDTH;
      assign tile_y     = $signed({28'd0, row_of[i]}) * BLOCK_WIDTH;
      assign overlap[i] = (mario_x < tile_x + BLOCK_WIDTH) && (mario_x + CHARACTER_WIDTH > tile_x) &&
                          (mario_y < tile_y + BLOCK_WIDTH) && (mario_y + CHARACTER_WIDTH > tile_y);
   end

   assign hit           = overlap & coin_en & ~collected;
   assign all_collected = (|coin_en) && ((collected & coin_en) == coin_en);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      hit_cnt = 0;
      for (int i = 0; i < NUM_COINS; i++) hit_cnt = hit_cnt + 32'(hit[i]);
      score_sum = SUM_W'(score) + SUM_W'(hit_cnt * COIN_VALUE);
   end

   // Restores are scanned first so any pending clear overrides them.
   always_comb begin
      pick_idx   = '0;
      pick_valid = |clr_pend;
`ifdef COIN_COLLECTOR_RESPAWN_EN
      pick_valid   = pick_valid | (|rst_pend);
      pick_restore = (clr_pend == '0);
      for (int i = NUM_COINS - 1; i >= 0; i--) if (rst_pend[i]) pick_idx = IDX_W'(i);
`endif
      for (int i = NUM_COINS - 1; i >= 0; i--) if (clr_pend[i]) pick_idx = IDX_W'(i);
   end

   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tile_req   <= 1'b0;
         tile_row   <= '0;
         tile_col   <= '0;
         tile_data  <= '0;
         cur_idx    <= '0;
         collected  <= '0;
         clr_pend   <= '0;
         score      <= '0;
         coin_event <= 1'b0;
`ifdef COIN_COLLECTOR_RESPAWN_EN
         rst_pend    <= '0;
         req_restore <= 1'b0;
         for (int i = 0; i < NUM_COINS; i++) respawn_cnt[i] <= '0;
`endif
      end else begin
         coin_event <= |hit;
         score      <= (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_WIDTH-1:0] : score_sum[SCORE_WIDTH-1:0];
         // NOTE: later non-blocking writes to the same bit win, so the ack path below overrides these.
         collected  <= collected | hit;
         clr_pend   <= clr_pend | hit;
`ifdef COIN_COLLECTOR_RESPAWN_EN
         for (int i = 0; i < NUM_COINS; i++) begin
            if (respawn_cnt[i] != '0) begin
               respawn_cnt[i] <= respawn_cnt[i] - 1'b1;
               if (respawn_cnt[i] == CNT_W'(1)) rst_pend[i] <= 1'b1;
            end
         end
`endif
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= REQ;
                  tile_req <= 1'b1;
                  cur_idx  <= pick_idx;
                  tile_row <= row_of[pick_idx];
                  tile_col <= col_of[pick_idx];
`ifdef COIN_COLLECTOR_RESPAWN_EN
                  req_restore <= pick_restore;
                  tile_data   <= pick_restore ? 8'(TKN) : 8'(SKY);
`else
                  tile_data <= 8'(SKY);
`endif
               end
            end
            REQ: begin
               if (tile_ack) begin
                  state    <= IDLE;
                  tile_req <= 1'b0;
`ifdef COIN_COLLECTOR_RESPAWN_EN
                  if (req_restore) begin
                     rst_pend[cur_idx]  <= 1'b0;
                     collected[cur_idx] <= 1'b0;
                  end else begin
                     clr_pend[cur_idx] <= 1'b0;
                     if (RESPAWN_CYCLES == 0) rst_pend[cur_idx] <= 1'b1;
                     else respawn_cnt[cur_idx] <= CNT_W'(RESPAWN_CYCLES);
                  end
`else
                  clr_pend[cur_idx] <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coin_collector.sv
// Directed bench for coin_collector: collection, saturation, write-back handshake, reset abandon.
// Exercises the respawn path too when built with COIN_COLLECTOR_RESPAWN_EN.
module tb_coin_collector;

   localparam int N = 4;

   logic               vga_clock = 1'b0;
   logic               reset;
   logic signed [31:0] mario_x, mario_y;
   logic [N*4-1:0]     coin_row;
   logic [N*5-1:0]     coin_col;
   logic [N-1:0]       coin_en;
   logic               tile_ack;

   logic               tile_req;
   logic [3:0]         tile_row;
   logic [4:0]         tile_col;
   logic [7:0]         tile_data;
   logic [N-1:0]       collected;
   logic [9:0]         score;
   logic               coin_event, all_collected;

   logic               sat_tile_req;
   logic [3:0]         sat_tile_row;
   logic [4:0]         sat_tile_col;
   logic [7:0]         sat_tile_data;
   logic [N-1:0]       sat_collected;
   logic [1:0]         sat_score;
   logic               sat_coin_event, sat_all_collected;

   int n_checks = 0;
   int n_errors = 0;

   coin_collector #(.NUM_COINS(N), .RESPAWN_CYCLES(10)) dut (
      .vga_clock(vga_clock), .reset(reset), .mario_x(mario_x), .mario_y(mario_y),
      .coin_row(coin_row), .coin_col(coin_col), .coin_en(coin_en),
      .tile_req(tile_req), .tile_row(tile_row), .tile_col(tile_col), .tile_data(tile_data),
      .tile_ack(tile_ack), .collected(collected), .score(score),
      .coin_event(coin_event), .all_collected(all_collected)
   );

   // Narrow score instance to reach saturation with only four coins.
   coin_collector #(.NUM_COINS(N), .SCORE_WIDTH(2), .RESPAWN_CYCLES(10)) dut_sat (
      .vga_clock(vga_clock), .reset(reset), .mario_x(mario_x), .mario_y(mario_y),
      .coin_row(coin_row), .coin_col(coin_col), .coin_en(coin_en),
      .tile_req(sat_tile_req), .tile_row(sat_tile_row), .tile_col(sat_tile_col),
      .tile_data(sat_tile_data), .tile_ack(tile_ack), .collected(sat_collected),
      .score(sat_score), .coin_event(sat_coin_event), .all_collected(sat_all_collected)
   );

   always #5 vga_clock = ~vga_clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge vga_clock);
         @(negedge vga_clock);
      end
   endtask

   task automatic set_coin(input int i, input logic [3:0] row, input logic [4:0] col);
      coin_row[i*4 +: 4] = row;
      coin_col[i*5 +: 5] = col;
   endtask

   task automatic count_reqs(input int cycles, output int reqs);
      reqs = 0;
      for (int c = 0; c < cycles; c++) begin
         step(1);
         if (tile_req) reqs++;
      end
   endtask

   initial begin
      int stable;
      int reqs;
      int wait_n;

      reset    = 1'b0;
      tile_ack = 1'b0;
      coin_en  = 4'b0001;
      coin_row = '0;
      coin_col = '0;
      set_coin(0, 6, 6);
      set_coin(1, 6, 7);
      set_coin(2, 7, 6);
      set_coin(3, 7, 7);
      mario_x = 240;
      mario_y = 240;
      @(negedge vga_clock);
      @(negedge vga_clock);

      // Reset holds everything idle even though the player overlaps coin 0.
      check("rst_tile_req", 32'(tile_req), 0);
      check("rst_score", 32'(score), 0);
      check("rst_collected", 32'(collected), 0);
      check("rst_coin_event", 32'(coin_event), 0);
      check("rst_all_collected", 32'(all_collected), 0);
      check("rst_tile_row", 32'(tile_row), 0);
      check("rst_tile_data", 32'(tile_data), 0);

      // First edge after release collects.
      reset = 1'b1;
      step(1);
      check("first_collected", 32'(collected), 32'h1);
      check("first_score", 32'(score), 1);
      check("first_event", 32'(coin_event), 1);
      check("first_all", 32'(all_collected), 1);
      check("first_no_req_yet", 32'(tile_req), 0);
      step(1);
      check("event_one_pulse", 32'(coin_event), 0);
      check("clr_req", 32'(tile_req), 1);
      check("clr_row", 32'(tile_row), 6);
      check("clr_col", 32'(tile_col), 6);
      check("clr_data", 32'(tile_data), 1);

      // Stall with ack low; moving the coin must not disturb the latched tile.
      set_coin(0, 3, 9);
      stable = 0;
      for (int c = 0; c < 50; c++) begin
         step(1);
         if (tile_req && tile_row == 4'd6 && tile_col == 5'd6 && tile_data == 8'd1) stable++;
      end
      check("stall_stable_cycles", 32'(stable), 50);
      set_coin(0, 6, 6);
      check("no_rescore_while_overlap", 32'(score), 1);
      tile_ack = 1'b1;
      step(1);
      tile_ack = 1'b0;
      check("ack_drops_req", 32'(tile_req), 0);

`ifdef COIN_COLLECTOR_RESPAWN_EN
      // Ack edge loads 10, ten decrements raise the restore, one more edge issues it.
      wait_n = 0;
      while (!tile_req && wait_n < 100) begin
         step(1);
         wait_n++;
      end
      check("respawn_delay", 32'(wait_n), 11);
      check("restore_data", 32'(tile_data), 4);
      check("restore_row", 32'(tile_row), 6);
      check("restore_still_collected", 32'(collected), 32'h1);
      tile_ack = 1'b1;
      step(1);
      tile_ack = 1'b0;
      check("restore_clears_collected", 32'(collected), 0);
      step(1);
      check("recollect_flag", 32'(collected), 32'h1);
      check("recollect_score", 32'(score), 2);
      check("recollect_event", 32'(coin_event), 1);
`else
      count_reqs(20, reqs);
      check("no_reissue_reqs", 32'(reqs), 0);
      check("stays_collected", 32'(collected), 32'h1);
      check("score_after_write", 32'(score), 1);
`endif

      // Boundary: edge-touching on each side is not overlap.
      reset   = 1'b0;
      mario_x = 198;
      mario_y = 240;
      coin_en = 4'b0001;
      step(1);
      reset = 1'b1;
      step(3);
      check("touch_left_score", 32'(score), 0);
      mario_x = 280;
      step(2);
      check("touch_right_score", 32'(score), 0);
      mario_x = 240;
      mario_y = 198;
      step(2);
      check("touch_top_score", 32'(score), 0);
      mario_y = 240;
      coin_en = 4'b0000;
      step(2);
      check("disabled_score", 32'(score), 0);
      check("disabled_all", 32'(all_collected), 0);
      mario_x = 199;
      coin_en = 4'b0001;
      step(1);
      check("overlap_1px_score", 32'(score), 1);
      check("ack_in_idle_prep_req", 32'(tile_req), 0);

      // Reset asserted in the middle of a handshake abandons the write.
      step(1);
      check("mid_req_high", 32'(tile_req), 1);
      reset = 1'b0;
      #1;
      check("async_rst_req", 32'(tile_req), 0);
      check("async_rst_score", 32'(score), 0);
      check("async_rst_collected", 32'(collected), 0);
      mario_x = -100;
      mario_y = -100;
      @(negedge vga_clock);
      reset = 1'b1;
      count_reqs(10, reqs);
      check("no_req_after_abandon", 32'(reqs), 0);

      // Two adjacent coins in one edge; acks held high across IDLE do not retire anything.
      coin_en = 4'b0011;
      mario_x = 240;
      mario_y = 240;
      step(1);
      check("dual_score", 32'(score), 2);
      check("dual_collected", 32'(collected), 32'h3);
      check("dual_event", 32'(coin_event), 1);
      check("dual_all", 32'(all_collected), 1);
      step(1);
      check("dual_single_pulse", 32'(coin_event), 0);
      check("dual_first_col", 32'(tile_col), 6);
      check("dual_first_req", 32'(tile_req), 1);
      tile_ack = 1'b1;
      step(1);
      check("dual_first_retired", 32'(tile_req), 0);
      step(1);
      check("dual_second_req", 32'(tile_req), 1);
      check("dual_second_row", 32'(tile_row), 6);
      check("dual_second_col", 32'(tile_col), 7);
      step(1);
      tile_ack = 1'b0;
      check("dual_second_retired", 32'(tile_req), 0);
      count_reqs(3, reqs);
      check("dual_no_extra_req", 32'(reqs), 0);

      // Saturation on the 2-bit score instance; the 10-bit one keeps counting.
      reset   = 1'b0;
      mario_x = -100;
      mario_y = -100;
      coin_en = 4'b0001;
      step(1);
      reset   = 1'b1;
      mario_x = 240;
      mario_y = 240;
      step(1);
      check("sat_step1", 32'(sat_score), 1);
      coin_en = 4'b0111;
      step(1);
      check("sat_step2", 32'(sat_score), 3);
      check("wide_step2", 32'(score), 3);
      coin_en = 4'b1111;
      step(1);
      check("sat_hold", 32'(sat_score), 3);
      check("sat_event", 32'(sat_coin_event), 1);
      check("wide_step3", 32'(score), 4);
      check("all_four", 32'(all_collected), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/coin_collector.md
COIN_COLLECTOR -- requirements
Module: coin_collector

Interface
REQ-001 Parameter NUM_COINS, default 4: number of collectible coin tiles tracked, 1..16.
REQ-002 Parameter BLOCK_WIDTH, default 40: tile edge in pixels.
REQ-003 Parameter CHARACTER_WIDTH, default 42: player bounding-box edge in pixels.
REQ-004 Parameter SCORE_WIDTH, default 10: score register width; COIN_VALUE, default 1: points per coin.
REQ-005 Parameters SKY, default 1, and TKN, default 4: tile codes written back; RESPAWN_CYCLES, default 1000.
REQ-006 vga_clock  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 mario_x, mario_y  in  32 signed each  player top-left pixel position.
REQ-009 coin_row  in  NUM_COINS*4  packed tile row per coin; coin_col  in  NUM_COINS*5  packed tile column per coin; coin i at slice i.
REQ-010 coin_en  in  NUM_COINS  per-coin enable; disabled coin is never collected.
REQ-011 tile_req  out  1; tile_row  out  4; tile_col  out  5; tile_data  out  8: background write request.
REQ-012 tile_ack  in  1  background write accepted.
REQ-013 collected  out  NUM_COINS  per-coin collected flag; score  out  SCORE_WIDTH; coin_event  out  1; all_collected  out  1.

Function
REQ-014 Overlap of coin i SHALL be true when [mario_x, mario_x+CHARACTER_WIDTH) intersects [col*BLOCK_WIDTH, (col+1)*BLOCK_WIDTH) and the same holds for y with row; edge-touching (zero-width intersection) is not overlap.
REQ-015 Each coin SHALL have state ACTIVE or COLLECTED; ACTIVE->COLLECTED on the edge where coin_en[i] and overlap are both true.
REQ-016 On that edge collected[i] SHALL set, a clear request for coin i SHALL become pending, and score SHALL add k*COIN_VALUE, where k is the number of coins collected on that edge.
REQ-017 Score SHALL saturate at 2^SCORE_WIDTH-1 and never wrap.
REQ-018 coin_event SHALL be high for exactly one cycle after any edge with k>=1; simultaneous collections give one pulse.
REQ-019 all_collected SHALL be high when every enabled coin is COLLECTED and at least one coin is enabled.
REQ-020 Write-back FSM states IDLE and REQ; in IDLE with any pending request, latch lowest-index pending coin, go to REQ.
REQ-021 In REQ tile_req SHALL be 1 with tile_row/tile_col/tile_data stable; tile_data=SKY for clear requests.
REQ-022 Sampled tile_ack=1 in REQ SHALL retire that request, drop tile_req next cycle, return to IDLE; minimum 2 cycles per write.
REQ-023 tile_ack while in IDLE SHALL be ignored.
REQ-024 A coin in COLLECTED SHALL not re-collect or re-score while the player still overlaps it.
REQ-025 Coordinate changes on coin_row/coin_col while a request is in REQ SHALL not alter latched tile_row/tile_col.

Reset
REQ-026 reset low SHALL immediately force all coins ACTIVE, pending requests clear, FSM IDLE, tile_req 0, tile_row/tile_col/tile_data 0, collected 0, score 0, coin_event 0, all_collected 0.
REQ-027 Reset asserted mid-handshake SHALL abandon the request; no write is reissued after release.
REQ-028 First collection SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro COIN_COLLECTOR_RESPAWN_EN SHALL compile in coin respawn.
REQ-030 With it: after coin i's clear write is acked, a per-coin counter loads RESPAWN_CYCLES and decrements each cycle; at zero a restore request (tile_data=TKN) becomes pending; on its ack the coin returns ACTIVE and collected[i] clears.
REQ-031 With it: clear requests SHALL win arbitration over restore requests; lower index wins within a class.
REQ-032 Without it: no counters or restore logic; coins stay COLLECTED until reset.

Verification
REQ-033 Player at (240,240), coin 0 at row 6 col 6, coin_en=4'b0001 -> collected=0001, score=1, coin_event one pulse, tile_req with row 6, col 6, data 1.
REQ-034 Coins 0 and 1 at adjacent tiles both overlapped same edge -> score +2, single coin_event, clears issued coin 0 then coin 1.
REQ-035 score preset to 1023 via repeated collections, one more coin -> score stays 1023.
REQ-036 tile_ack held low 50 cycles -> tile_req, row, col stable 50 cycles; ack -> tile_req low next cycle.
REQ-037 reset pulsed low during REQ -> tile_req 0 immediately, score 0, no request after release.
REQ-038 COIN_COLLECTOR_RESPAWN_EN, RESPAWN_CYCLES=10 -> restore write with data 4 after 10 cycles; collected[0] clears on ack; recollection scores again.
